// File: rtl/imm_encoder.sv
// rtl/imm_encoder.sv - RISC-V immediate/field encoder with an OUT_DEPTH-entry output FIFO.
// Optional immediate range checking is enabled by defining IMM_RANGE_CHECK_EN.
module imm_encoder #(
  parameter int OUT_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  imm_src,
  input  logic [31:0] imm,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err,
  output logic [15:0] err_count
);

  localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(OUT_DEPTH);

  typedef enum logic [2:0] {
    FMT_I = 3'b000,
    FMT_S = 3'b001,
    FMT_B = 3'b010,
    FMT_U = 3'b011,
    FMT_J = 3'b100
  } fmt_e;

  logic [31:0]   enc_instr;
  logic          enc_err;
  logic          range_err;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          accept;
  logic          pop;
  logic [31:0]   instr_mem [OUT_DEPTH];
  logic          err_mem   [OUT_DEPTH];

  always_comb begin
    enc_instr = 32'h0;
    enc_err   = 1'b0;
    case (imm_src)
      FMT_I: enc_instr = {imm[11:0], rs1, funct3, rd, opcode};
      FMT_S: enc_instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FMT_B: enc_instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      FMT_U: enc_instr = {imm[31:12], rd, opcode};
      FMT_J: enc_instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: enc_err = 1'b1;
    endcase
    enc_err = enc_err | range_err;
  end

`ifdef IMM_RANGE_CHECK_EN
  // Flag immediates that do not fit the format; the truncated word is still stored.
  always_comb begin
    range_err = 1'b0;
    case (imm_src)
      FMT_I, FMT_S: range_err = !((&imm[31:11]) || !(|imm[31:11]));
      FMT_B:        range_err = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
      FMT_J:        range_err = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
      FMT_U:        range_err = |imm[11:0];
      default:      range_err = 1'b0;
    endcase
  end
`else
  assign range_err = 1'b0;
`endif

  assign full      = (count == FULL_CNT);
  assign in_ready  = !full;
  assign out_valid = (count != '0);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_instr = out_valid ? instr_mem[rd_ptr] : 32'h0;
  assign out_err   = out_valid ? err_mem[rd_ptr] : 1'b0;

  // Storage is not reset; pointers and occupancy alone define valid contents.
  always_ff @(posedge clk) begin
    if (accept) begin
      instr_mem[wr_ptr] <= enc_instr;
      err_mem[wr_ptr]   <= enc_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      err_count <= 16'h0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (accept && enc_err && (err_count != 16'hFFFF)) begin
        err_count <= err_count + 16'h1;
      end
    end
  end

endmodule
